// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: FSM state encoding,
// ASCII constants and the default response characters.
// Build option: CMD_ECHO_EN adds the SEND_ECHO state to the state enum.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_SEND_0    = 3'd3,
        ST_SEND_1    = 3'd4
`ifdef CMD_ECHO_EN
        ,
        ST_SEND_ECHO = 3'd5
`endif
    } state_t;

    localparam logic [7:0] ASCII_ZERO       = 8'h30;
    localparam logic [7:0] ASCII_NINE       = 8'h39;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] DEFAULT_ACK_CHAR = 8'h4B;
    localparam logic [7:0] DEFAULT_NAK_CHAR = 8'h45;

    // True for the ASCII characters '0'..'9'.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_tx_byte_sender.sv
// Pushes one byte into the UART TX FIFO, honouring the FIFO full flag.
//
// Handshake: the requester holds req high with a stable tx_byte. On the first
// cycle where req is high, full is sampled low and no push is in flight, the
// sender registers wr_en=1 with the byte for exactly one cycle; done is high
// in that same cycle. The requester must update tx_byte (or drop req) on the
// done cycle; the next request is not considered until the cycle after done,
// so back-to-back bytes are spaced two cycles apart.
module uart_tx_byte_sender (
    input  logic       clk_1,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] tx_byte,
    input  logic       tx_fifo_full,
    output logic       tx_fifo_wr_en,
    output logic [7:0] tx_fifo_data,
    output logic       done
);

    // One-cycle push strobe; the data register holds its value between pushes.
    always_ff @(posedge clk_1) begin
        if (reset) begin
            tx_fifo_wr_en <= 1'b0;
            tx_fifo_data  <= 8'h00;
        end else begin
            tx_fifo_wr_en <= 1'b0;
            if (req && !tx_fifo_wr_en && !tx_fifo_full) begin
                tx_fifo_wr_en <= 1'b1;
                tx_fifo_data  <= tx_byte;
            end
        end
    end

    assign done = tx_fifo_wr_en;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Assembles NUM_DIGITS ASCII digits popped from the UART RX FIFO into a BCD
// display frame, commits it, and answers each frame or bad byte with a
// two-byte response (ACK/NAK + CR) pushed into the UART TX FIFO.
// Build option: CMD_ECHO_EN echoes every accepted digit before any response.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_DIGITS      = 4,
    parameter int         DIGIT_IDX_WIDTH = 2,
    parameter int         TIMEOUT_CYCLES  = 10000,
    parameter int         TIMEOUT_WIDTH   = 14,
    parameter logic [7:0] ACK_CHAR        = DEFAULT_ACK_CHAR,
    parameter logic [7:0] NAK_CHAR        = DEFAULT_NAK_CHAR
) (
    input  logic                    clk_1,
    input  logic                    reset,
    input  logic                    rx_fifo_empty,
    output logic                    rx_fifo_rd_en,
    input  logic [7:0]              rx_fifo_data,
    input  logic                    tx_fifo_full,
    output logic                    tx_fifo_wr_en,
    output logic [7:0]              tx_fifo_data,
    output logic [4*NUM_DIGITS-1:0] disp_digits,
    output logic                    disp_update,
    output logic                    busy
);

    localparam int SHADOW_W = 4 * (NUM_DIGITS - 1);
    localparam logic [DIGIT_IDX_WIDTH-1:0] IDX_LAST   = DIGIT_IDX_WIDTH'(NUM_DIGITS - 1);
    localparam logic [TIMEOUT_WIDTH-1:0]   TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                     state;
    logic [SHADOW_W-1:0]        shadow;
    logic [DIGIT_IDX_WIDTH-1:0] idx;
    logic [TIMEOUT_WIDTH-1:0]   timer;
    logic [7:0]                 send_byte;
    logic                       send_req;
    logic                       send_done;
    logic                       timer_expire;
`ifdef CMD_ECHO_EN
    logic                       echo_final;
`endif

    // A partial frame has sat idle for the full timeout window.
    assign timer_expire = (idx != '0) && (timer == TIMER_LAST);

    // Sequencer FSM: fetch/decode digits, commit frames, drive responses.
    always_ff @(posedge clk_1) begin
        if (reset) begin
            state         <= ST_IDLE;
            shadow        <= '0;
            idx           <= '0;
            timer         <= '0;
            send_byte     <= 8'h00;
            send_req      <= 1'b0;
            rx_fifo_rd_en <= 1'b0;
            disp_digits   <= '0;
            disp_update   <= 1'b0;
            busy          <= 1'b0;
`ifdef CMD_ECHO_EN
            echo_final    <= 1'b0;
`endif
        end else begin
            rx_fifo_rd_en <= 1'b0;
            disp_update   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Expiry clears the frame first; a waiting byte still
                    // gets fetched and begins a fresh frame.
                    if (timer_expire) begin
                        idx    <= '0;
                        shadow <= '0;
                        timer  <= '0;
                    end else if ((idx != '0) && rx_fifo_empty) begin
                        timer <= timer + 1'b1;
                    end
                    if (!rx_fifo_empty) begin
                        state         <= ST_FETCH;
                        rx_fifo_rd_en <= 1'b1;
                        timer         <= '0;
                        busy          <= 1'b1;
                    end else begin
                        busy <= (idx != '0) && !timer_expire;
                    end
                end
                ST_FETCH: begin
                    timer <= '0;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (is_digit(rx_fifo_data)) begin
                        if (idx == IDX_LAST) begin
                            disp_digits <= {shadow, rx_fifo_data[3:0]};
                            disp_update <= 1'b1;
                            idx         <= '0;
                            shadow      <= '0;
                            send_req    <= 1'b1;
`ifdef CMD_ECHO_EN
                            send_byte   <= rx_fifo_data;
                            echo_final  <= 1'b1;
                            state       <= ST_SEND_ECHO;
`else
                            send_byte   <= ACK_CHAR;
                            state       <= ST_SEND_0;
`endif
                        end else begin
                            shadow <= SHADOW_W'({shadow, rx_fifo_data[3:0]});
                            idx    <= idx + 1'b1;
`ifdef CMD_ECHO_EN
                            send_byte  <= rx_fifo_data;
                            send_req   <= 1'b1;
                            echo_final <= 1'b0;
                            state      <= ST_SEND_ECHO;
`else
                            state      <= ST_IDLE;
`endif
                        end
                    end else begin
                        idx       <= '0;
                        shadow    <= '0;
                        send_byte <= NAK_CHAR;
                        send_req  <= 1'b1;
                        state     <= ST_SEND_0;
                    end
                end
`ifdef CMD_ECHO_EN
                ST_SEND_ECHO: begin
                    if (send_done) begin
                        if (echo_final) begin
                            send_byte <= ACK_CHAR;
                            state     <= ST_SEND_0;
                        end else begin
                            send_req <= 1'b0;
                            busy     <= (idx != '0);
                            state    <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_SEND_0: begin
                    if (send_done) begin
                        send_byte <= ASCII_CR;
                        state     <= ST_SEND_1;
                    end
                end
                ST_SEND_1: begin
                    if (send_done) begin
                        send_req <= 1'b0;
                        busy     <= (idx != '0);
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte_sender u_sender (
        .clk_1         (clk_1),
        .reset         (reset),
        .req           (send_req),
        .tx_byte       (send_byte),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_wr_en (tx_fifo_wr_en),
        .tx_fifo_data  (tx_fifo_data),
        .done          (send_done)
    );

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: RX/TX FIFO models, frame-level reference
// model, directed scenarios plus randomized frames with TX backpressure.
module tb_uart_cmd_sequencer;

  localparam int N  = 4;
  localparam int TC = 10000;
  localparam logic [7:0] K_CHAR  = 8'h4B;
  localparam logic [7:0] E_CHAR  = 8'h45;
  localparam logic [7:0] CR_CHAR = 8'h0D;

  logic        clk_1 = 1'b0;
  logic        reset = 1'b1;
  logic        rx_fifo_empty = 1'b1;
  logic        rx_fifo_rd_en;
  logic [7:0]  rx_fifo_data = 8'h00;
  logic        tx_fifo_full = 1'b0;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_data;
  logic [15:0] disp_digits;
  logic        disp_update;
  logic        busy;

  uart_cmd_sequencer dut (
    .clk_1         (clk_1),
    .reset         (reset),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_rd_en (rx_fifo_rd_en),
    .rx_fifo_data  (rx_fifo_data),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_data  (tx_fifo_data),
    .disp_digits   (disp_digits),
    .disp_update   (disp_update),
    .busy          (busy)
  );

  // clock / reset block
  always #5 clk_1 = ~clk_1;

  // scoreboard and model state
  logic [7:0]  rx_mem[$];
  logic [7:0]  exp_q[$];
  logic [15:0] exp_disp_q[$];
  logic [15:0] exp_disp_now = 16'h0;
  int          frame_len = 0;
  int          frame_val = 0;
  int          idle_cnt = 0;
  logic        pend_valid = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  int          cyc = 0;
  int          lat_ref = 0;
  int          lat_exp = 3;
  logic        full_dirty = 1'b1;
  int          full_hold = 0;
  logic        rand_full = 1'b0;
  int          fall_cyc = -10;
  int          first_wr_cyc = 0;
  int          wr_since_fall = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: consumes one byte in the order the DUT pops it.
  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) begin
      frame_val = frame_val * 16 + (int'(b) - 48);
      frame_len++;
`ifdef CMD_ECHO_EN
      exp_q.push_back(b);
`endif
      if (frame_len == N) begin
        exp_disp_q.push_back(16'(frame_val));
        exp_disp_now = 16'(frame_val);
        exp_q.push_back(K_CHAR);
        exp_q.push_back(CR_CHAR);
        frame_len = 0;
        frame_val = 0;
      end
    end else begin
      frame_len = 0;
      frame_val = 0;
      exp_q.push_back(E_CHAR);
      exp_q.push_back(CR_CHAR);
    end
  endtask

  // One clock: observe outputs #1 after the edge, then drive the next inputs.
  task automatic step();
    logic prev_full;
    logic [7:0] b;
    @(posedge clk_1);
    #1;
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: got %0d cycles expected below 90000", cyc);
      $fatal(1, "watchdog");
    end
    prev_full = tx_fifo_full;
    if (prev_full) full_dirty = 1'b1;

    if (tx_fifo_wr_en) begin
      check("wr_en_after_full", prev_full, 1'b0);
      check("tx_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("tx_byte", tx_fifo_data, exp_q.pop_front());
      if (!full_dirty) check("tx_latency", cyc - lat_ref, lat_exp);
      if (wr_since_fall == 0) first_wr_cyc = cyc;
      wr_since_fall++;
      lat_ref = cyc;
      lat_exp = 2;
      full_dirty = 1'b0;
    end

    if (disp_update) begin
      check("disp_pending", exp_disp_q.size() != 0, 1'b1);
      if (exp_disp_q.size() != 0) check("disp_value", disp_digits, exp_disp_q.pop_front());
    end

    // RX FIFO read data is valid only in the cycle after the pop strobe.
    if (pend_valid) begin
      rx_fifo_data = pend_byte;
      pend_valid = 1'b0;
    end else begin
      rx_fifo_data = 8'($urandom);
    end

    if (rx_fifo_rd_en) begin
      check("pop_during_resp", exp_q.size(), 0);
      check("pop_nonempty", rx_mem.size() != 0, 1'b1);
      if (rx_mem.size() != 0) begin
        b = rx_mem.pop_front();
        pend_valid = 1'b1;
        pend_byte = b;
        model_byte(b);
      end
      lat_ref = cyc;
      lat_exp = 3;
      full_dirty = 1'b0;
      idle_cnt = 0;
    end
    rx_fifo_empty = (rx_mem.size() == 0);

    if (full_hold > 0) begin
      tx_fifo_full = 1'b1;
      full_hold--;
    end else if (rand_full) begin
      tx_fifo_full = ($urandom_range(0, 3) == 0);
    end else begin
      tx_fifo_full = 1'b0;
    end
    if (prev_full && !tx_fifo_full) begin
      fall_cyc = cyc;
      wr_since_fall = 0;
    end

    // Partial frame abandoned after a long quiet period.
    if (frame_len != 0 && rx_mem.size() == 0 && exp_q.size() == 0 && !pend_valid)
      idle_cnt++;
    if (idle_cnt >= TC) begin
      frame_len = 0;
      frame_val = 0;
      idle_cnt = 0;
    end
  endtask

  // driver tasks
  task automatic send_rx(input logic [7:0] b, input int gap);
    rx_mem.push_back(b);
    rx_fifo_empty = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_rx(s[i], gap);
  endtask

  task automatic drain();
    int n = 0;
    while ((rx_mem.size() != 0 || exp_q.size() != 0 || pend_valid || exp_disp_q.size() != 0) && n < 5000) begin
      step();
      n++;
    end
    check("drain_bound", n < 5000, 1'b1);
    repeat (4) step();
    check("busy_quiet", busy, frame_len != 0);
    check("disp_digits", disp_digits, exp_disp_now);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (exp_q.size() == 0 && n < 200) begin
      step();
      n++;
    end
    check("resp_bound", n < 200, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_mem.delete();
    exp_q.delete();
    exp_disp_q.delete();
    frame_len = 0;
    frame_val = 0;
    exp_disp_now = 16'h0;
    idle_cnt = 0;
    pend_valid = 1'b0;
    full_hold = 0;
    tx_fifo_full = 1'b0;
    rx_fifo_empty = 1'b1;
    full_dirty = 1'b1;
    repeat (3) step();
    check("rst_rd_en", rx_fifo_rd_en, 1'b0);
    check("rst_wr_en", tx_fifo_wr_en, 1'b0);
    check("rst_tx_data", tx_fifo_data, 8'h00);
    check("rst_disp", disp_digits, 16'h0000);
    check("rst_update", disp_update, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    logic [7:0] b;
    do_reset();

    // basic frame with latency checks
    send_str("3503", 0);
    drain();

    // partial frame, long idle, then a new frame
    send_str("13", 2);
    drain();
    repeat (TC + 50) step();
    check("busy_after_timeout", busy, frame_len != 0);
    send_str("0313", 1);
    drain();

    // invalid byte leaves display unchanged
    send_str("1A", 1);
    drain();
    send_str("3503", 0);
    drain();

    // TX backpressure across a response, more bytes waiting in RX
    send_str("12345678", 0);
    wait_resp();
    tx_fifo_full = 1'b1;
    full_hold = 19;
    drain();
    check("push_after_full_drop", first_wr_cyc, fall_cyc + 1);

    // reset mid-frame, then during a stalled response
    send_str("12", 0);
    repeat (10) step();
    do_reset();
    send_str("7777", 0);
    wait_resp();
    tx_fifo_full = 1'b1;
    full_hold = 100;
    repeat (8) step();
    do_reset();
    repeat (5) step();
    check("no_push_after_reset", tx_fifo_wr_en, 1'b0);
    send_str("3503", 0);
    drain();

    // randomized frames, gaps and backpressure
    for (int f = 0; f < 40; f++) begin
      rand_full = (f % 2 == 1);
      for (int k = 0; k < $urandom_range(1, N + 1); k++) begin
        if ($urandom_range(0, 9) == 0) begin
          do b = 8'($urandom); while (b >= 8'h30 && b <= 8'h39);
        end else begin
          b = 8'($urandom_range(48, 57));
        end
        send_rx(b, $urandom_range(0, 15));
      end
      if (f % 8 == 7) drain();
    end
    rand_full = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
